// File: rtl/xor_equiv_sequencer.sv
// Exhaustive a/b sweep that drives a reference XOR and a gate-level XOR,
// compares their outputs per vector and records mismatch count and first failure.
module xor_equiv_sequencer #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s_ref,
    input  logic [WIDTH-1:0] s_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int unsigned VW = 2 * WIDTH;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   settle_cnt;
    logic            first_seen;
    logic            mismatch_c;

    assign a = vec[VW-1:WIDTH];
    assign b = vec[WIDTH-1:0];

    // Any differing lane counts as one failing vector.
    assign mismatch_c = (s_ref != s_dut);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            done <= 1'b0;
            // Abort outranks every other transition, but only once a sweep is running.
            if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            vec        <= '0;
                            err_count  <= '0;
                            pass       <= 1'b0;
                            first_seen <= 1'b0;
                            fail_a     <= '0;
                            fail_b     <= '0;
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= S_CHECK;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    S_CHECK: begin
                        if (mismatch_c) begin
                            if (err_count != {CNT_W{1'b1}}) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (!first_seen) begin
                                first_seen <= 1'b1;
                                fail_a     <= a;
                                fail_b     <= b;
                            end
                        end
                        if (vec == {VW{1'b1}}) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            vec        <= vec + VW'(1);
                            settle_cnt <= '0;
                            state      <= S_WAIT;
                        end
                    end
                    S_FINISH: begin
                        pass  <= (err_count == '0);
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
